// File: rtl/hazard_fwd_unit_if.sv
// Bundle between the ID stage and the hazard/forwarding controller.
// The ID side drives the instruction fields and flush; the controller returns
// stall, the per-port forward selects and its performance counters.
interface hazard_fwd_unit_if #(
    parameter int NRP    = 2,
    parameter int NSTAGE = 3,
    parameter int CNTW   = 32
);
    localparam int SELW = $clog2(NSTAGE);

    logic                   id_valid;
    logic [NRP*5-1:0]       id_rs;
    logic [NRP-1:0]         id_rs_used;
    logic [4:0]             id_rd;
    logic                   id_regwrite;
    logic                   id_is_load;
    logic                   flush;
    logic                   stall;
    logic [NRP*SELW-1:0]    fwd_sel;
    logic [CNTW-1:0]        stall_cnt;
    logic [CNTW-1:0]        fwd_cnt;

    // ID stage side
    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_is_load, flush,
        input  stall, fwd_sel, stall_cnt, fwd_cnt
    );

    // Controller side
    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_is_load, flush,
        output stall, fwd_sel, stall_cnt, fwd_cnt
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand bypass control for an in-order integer pipeline.
// Tracks the destination registers of the last NSTAGE issued instructions in a
// slot shift register and, each cycle, produces per-read-port forward selects
// and a load-use stall.
//
// Issue handshake: id_valid qualifies the ID instruction; stall is the
// backpressure (ID may advance only when stall=0). An instruction issues into
// EX exactly on an edge where id_valid=1, stall=0 and flush=0; every other
// edge pushes a bubble into slot 1.
module hazard_fwd_unit #(
    parameter int NRP      = 2,
    parameter int NSTAGE   = 3,
    parameter int LOAD_LAT = 1,
    parameter int CNTW     = 32
) (
    input logic              clock,
    input logic              reset,
    hazard_fwd_unit_if.slave bus
);
    localparam int SELW = $clog2(NSTAGE);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } slot_t;

    // slot_q[j] holds the instruction issued j cycles ago; slot 1 is in EX.
    slot_t               slot_q [1:NSTAGE];
    logic                stall_c;
    logic [NRP*SELW-1:0] sel_c;
    logic                issue;
    logic [CNTW-1:0]     stall_cnt_q;
    logic [CNTW-1:0]     fwd_cnt_q;

    // Youngest matching producer per port decides forward select or stall.
    always_comb begin : detect
        logic       found;
        logic       hazard;
        logic [4:0] rs;
        sel_c  = '0;
        hazard = 1'b0;
        found  = 1'b0;
        rs     = 5'd0;
        for (int p = 0; p < NRP; p++) begin
            rs    = bus.id_rs[5*p +: 5];
            found = 1'b0;
            for (int j = 1; j <= NSTAGE; j++) begin
                if (!found && bus.id_valid && bus.id_rs_used[p] && (rs != 5'd0) &&
                    slot_q[j].valid && slot_q[j].wr && (slot_q[j].rd == rs)) begin
                    found = 1'b1;
                    if (slot_q[j].ld && (j < 1 + LOAD_LAT)) begin
                        // Load data not yet available at this depth.
                        hazard = 1'b1;
                    end else if (j < NSTAGE) begin
                        // Slot NSTAGE is in WB and the regfile writes through.
                        sel_c[SELW*p +: SELW] = SELW'(j);
                    end
                end
            end
        end
        stall_c = hazard & ~bus.flush;
    end

    assign issue         = bus.id_valid & ~stall_c & ~bus.flush;
    assign bus.stall     = stall_c;
    assign bus.fwd_sel   = sel_c;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.fwd_cnt   = fwd_cnt_q;

    // Shift the slot register; issue the ID instruction or a bubble into slot 1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int j = 1; j <= NSTAGE; j++) begin
                slot_q[j] <= '0;
            end
        end else begin
            for (int j = NSTAGE; j >= 2; j--) begin
                slot_q[j] <= slot_q[j-1];
            end
            slot_q[1] <= issue ? {1'b1, bus.id_rd, bus.id_regwrite, bus.id_is_load} : '0;
        end
    end

    // Saturating performance counters for stall cycles and bypassed issues.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall_c && (stall_cnt_q != {CNTW{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNTW'(1);
            end
            if (issue && (|sel_c) && (fwd_cnt_q != {CNTW{1'b1}})) begin
                fwd_cnt_q <= fwd_cnt_q + CNTW'(1);
            end
        end
    end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: two configurations (3-stage/1-cycle load/32-bit
// counters and 4-stage/2-cycle load/4-bit counters) driven side by side,
// directed sequences plus random traffic, checked against a reference model.
module tb_hazard_fwd_unit;
    localparam int NRP   = 2;
    localparam int NST_A = 3;
    localparam int LL_A  = 1;
    localparam int CW_A  = 32;
    localparam int NST_B = 4;
    localparam int LL_B  = 2;
    localparam int CW_B  = 4;
    localparam int SW_A  = $clog2(NST_A);
    localparam int SW_B  = $clog2(NST_B);

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    hazard_fwd_unit_if #(.NRP(NRP), .NSTAGE(NST_A), .CNTW(CW_A)) bus_a ();
    hazard_fwd_unit_if #(.NRP(NRP), .NSTAGE(NST_B), .CNTW(CW_B)) bus_b ();

    hazard_fwd_unit #(.NRP(NRP), .NSTAGE(NST_A), .LOAD_LAT(LL_A), .CNTW(CW_A)) dut_a (
        .clock(clock), .reset(reset), .bus(bus_a.slave)
    );
    hazard_fwd_unit #(.NRP(NRP), .NSTAGE(NST_B), .LOAD_LAT(LL_B), .CNTW(CW_B)) dut_b (
        .clock(clock), .reset(reset), .bus(bus_b.slave)
    );

    // Per-DUT input drive variables (index 0 = A, 1 = B).
    logic           in_valid [2];
    logic [4:0]     in_rs    [2][NRP];
    logic [NRP-1:0] in_used  [2];
    logic [4:0]     in_rd    [2];
    logic           in_wr    [2];
    logic           in_ld    [2];
    logic           in_flush [2];

    assign bus_a.id_valid    = in_valid[0];
    assign bus_a.id_rs       = {in_rs[0][1], in_rs[0][0]};
    assign bus_a.id_rs_used  = in_used[0];
    assign bus_a.id_rd       = in_rd[0];
    assign bus_a.id_regwrite = in_wr[0];
    assign bus_a.id_is_load  = in_ld[0];
    assign bus_a.flush       = in_flush[0];
    assign bus_b.id_valid    = in_valid[1];
    assign bus_b.id_rs       = {in_rs[1][1], in_rs[1][0]};
    assign bus_b.id_rs_used  = in_used[1];
    assign bus_b.id_rd       = in_rd[1];
    assign bus_b.id_regwrite = in_wr[1];
    assign bus_b.id_is_load  = in_ld[1];
    assign bus_b.flush       = in_flush[1];

    // ---------------- reference model ----------------
    bit     m_v   [2][1:6];
    int     m_rd  [2][1:6];
    bit     m_wr  [2][1:6];
    bit     m_ld  [2][1:6];
    longint m_scnt[2];
    longint m_fcnt[2];
    bit     e_stall[2];
    int     e_sel [2][NRP];

    function automatic int nst(int k);
        return (k == 0) ? NST_A : NST_B;
    endfunction
    function automatic int lat(int k);
        return (k == 0) ? LL_A : LL_B;
    endfunction
    function automatic longint cmax(int k);
        return (k == 0) ? 64'd4294967295 : 64'd15;
    endfunction

    function automatic void model_reset(int k);
        for (int j = 1; j <= 6; j++) begin
            m_v[k][j] = 0; m_rd[k][j] = 0; m_wr[k][j] = 0; m_ld[k][j] = 0;
        end
        m_scnt[k] = 0;
        m_fcnt[k] = 0;
    endfunction

    // Scan oldest to youngest so the last hit is the youngest producer.
    function automatic void model_eval(int k);
        bit blocked;
        blocked = 0;
        for (int p = 0; p < NRP; p++) begin
            int prod;
            int need;
            prod = 0;
            e_sel[k][p] = 0;
            if (in_valid[k] && in_used[k][p] && in_rs[k][p] != 5'd0) begin
                for (int j = nst(k); j >= 1; j--) begin
                    if (m_v[k][j] && m_wr[k][j] && m_rd[k][j] == int'(in_rs[k][p])) prod = j;
                end
            end
            if (prod != 0) begin
                need = m_ld[k][prod] ? 1 + lat(k) : 1;
                if (prod < need) blocked = 1;
                else if (prod < nst(k)) e_sel[k][p] = prod;
            end
        end
        e_stall[k] = blocked && !in_flush[k];
    endfunction

    function automatic void model_clock(int k);
        bit enter;
        bit any;
        enter = in_valid[k] && !e_stall[k] && !in_flush[k];
        any = 0;
        for (int p = 0; p < NRP; p++) if (e_sel[k][p] != 0) any = 1;
        if (e_stall[k] && m_scnt[k] < cmax(k)) m_scnt[k]++;
        if (enter && any && m_fcnt[k] < cmax(k)) m_fcnt[k]++;
        for (int j = nst(k); j >= 2; j--) begin
            m_v[k][j] = m_v[k][j-1]; m_rd[k][j] = m_rd[k][j-1];
            m_wr[k][j] = m_wr[k][j-1]; m_ld[k][j] = m_ld[k][j-1];
        end
        m_v[k][1]  = enter;
        m_rd[k][1] = enter ? int'(in_rd[k]) : 0;
        m_wr[k][1] = enter && in_wr[k];
        m_ld[k][1] = enter && in_ld[k];
    endfunction

    // ---------------- DUT observation ----------------
    function automatic logic [63:0] obs_stall(int k);
        return (k == 0) ? 64'(bus_a.stall) : 64'(bus_b.stall);
    endfunction
    function automatic logic [63:0] obs_sel(int k, int p);
        return (k == 0) ? 64'(bus_a.fwd_sel[p*SW_A +: SW_A]) : 64'(bus_b.fwd_sel[p*SW_B +: SW_B]);
    endfunction
    function automatic logic [63:0] obs_scnt(int k);
        return (k == 0) ? 64'(bus_a.stall_cnt) : 64'(bus_b.stall_cnt);
    endfunction
    function automatic logic [63:0] obs_fcnt(int k);
        return (k == 0) ? 64'(bus_a.fwd_cnt) : 64'(bus_b.fwd_cnt);
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(int k);
        in_valid[k] = 1'b0;
        in_rs[k][0] = 5'd0;
        in_rs[k][1] = 5'd0;
        in_used[k]  = '0;
        in_rd[k]    = 5'd0;
        in_wr[k]    = 1'b0;
        in_ld[k]    = 1'b0;
        in_flush[k] = 1'b0;
    endtask

    task automatic drive(int k, int rs0, int rs1, logic [1:0] used, int rd, bit wr, bit ld);
        in_valid[k] = 1'b1;
        in_rs[k][0] = 5'(rs0);
        in_rs[k][1] = 5'(rs1);
        in_used[k]  = used;
        in_rd[k]    = 5'(rd);
        in_wr[k]    = wr;
        in_ld[k]    = ld;
        in_flush[k] = 1'b0;
    endtask

    // Called just after a falling edge with inputs set: check combinational
    // outputs, clock once, then check the counters.
    task automatic step();
        #1;
        for (int k = 0; k < 2; k++) begin
            model_eval(k);
            check_eq($sformatf("stall[%0d]", k), obs_stall(k), 64'(e_stall[k]));
            if (!e_stall[k]) begin
                for (int p = 0; p < NRP; p++)
                    check_eq($sformatf("fwd_sel[%0d][%0d]", k, p), obs_sel(k, p), 64'(e_sel[k][p]));
            end
        end
        @(posedge clock);
        for (int k = 0; k < 2; k++) model_clock(k);
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("stall_cnt[%0d]", k), obs_scnt(k), 64'(m_scnt[k]));
            check_eq($sformatf("fwd_cnt[%0d]", k), obs_fcnt(k), 64'(m_fcnt[k]));
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        idle(0);
        idle(1);
        reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("rst_stall[%0d]", k), obs_stall(k), 64'd0);
            check_eq($sformatf("rst_sel[%0d]", k), obs_sel(k, 0), 64'd0);
            check_eq($sformatf("rst_scnt[%0d]", k), obs_scnt(k), 64'd0);
            check_eq($sformatf("rst_fcnt[%0d]", k), obs_fcnt(k), 64'd0);
            model_reset(k);
        end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        idle(0);
        idle(1);
        @(negedge clock);
        do_reset();

        // ADDI x1 / ADDI x2 / ADD x3,x1,x2
        drive(0, 0, 0, 2'b01, 1, 1, 0); step();
        drive(0, 0, 0, 2'b01, 2, 1, 0); step();
        drive(0, 1, 2, 2'b11, 3, 1, 0); #1;
        check_eq("add_p0", obs_sel(0, 0), 64'd2);
        check_eq("add_p1", obs_sel(0, 1), 64'd1);
        check_eq("add_stall", obs_stall(0), 64'd0);
        step();
        check_eq("add_fcnt", obs_fcnt(0), 64'd1);
        // SUB x4,x3,x1: x1 sits in WB -> regfile
        drive(0, 3, 1, 2'b11, 4, 1, 0); #1;
        check_eq("sub_p0", obs_sel(0, 0), 64'd1);
        check_eq("sub_p1", obs_sel(0, 1), 64'd0);
        step();
        // AND x5,x4,x2
        drive(0, 4, 2, 2'b11, 5, 1, 0); #1;
        check_eq("and_p0", obs_sel(0, 0), 64'd1);
        check_eq("and_p1", obs_sel(0, 1), 64'd0);
        step();
        // LW x1,0(x0) then ADDI x2,x1,5 then SW x2,4(x0)
        drive(0, 0, 0, 2'b01, 1, 1, 1); step();
        drive(0, 1, 0, 2'b01, 2, 1, 0); #1;
        check_eq("lu_stall1", obs_stall(0), 64'd1);
        step();
        #1;
        check_eq("lu_stall_done", obs_stall(0), 64'd0);
        check_eq("lu_p0", obs_sel(0, 0), 64'd2);
        step();
        check_eq("lu_scnt", obs_scnt(0), 64'd1);
        drive(0, 0, 2, 2'b11, 0, 0, 0); #1;
        check_eq("sw_p1", obs_sel(0, 1), 64'd1);
        step();

        // x0 never matches; unused ports never match
        drive(0, 0, 0, 2'b01, 0, 1, 0); step();
        drive(0, 0, 0, 2'b11, 6, 1, 0); #1;
        check_eq("x0_p0", obs_sel(0, 0), 64'd0);
        check_eq("x0_p1", obs_sel(0, 1), 64'd0);
        check_eq("x0_stall", obs_stall(0), 64'd0);
        step();
        drive(0, 0, 0, 2'b01, 5, 1, 1); step();
        drive(0, 5, 5, 2'b00, 7, 1, 0); #1;
        check_eq("unused_stall", obs_stall(0), 64'd0);
        check_eq("unused_p0", obs_sel(0, 0), 64'd0);
        step();

        // flush during load-use stall
        drive(0, 0, 0, 2'b01, 7, 1, 1); step();
        drive(0, 7, 0, 2'b01, 8, 1, 0); #1;
        check_eq("flush_pre", obs_stall(0), 64'd1);
        in_flush[0] = 1'b1; #1;
        check_eq("flush_now", obs_stall(0), 64'd0);
        step();
        idle(0); step();
        drive(0, 8, 0, 2'b01, 9, 1, 0); #1;
        check_eq("flush_bubble", obs_sel(0, 0), 64'd0);
        step();

        // reset in the middle of a stall
        drive(0, 0, 0, 2'b01, 9, 1, 1); step();
        drive(0, 9, 0, 2'b01, 10, 1, 0); #1;
        check_eq("mid_pre", obs_stall(0), 64'd1);
        reset = 1'b1; #1;
        check_eq("mid_stall", obs_stall(0), 64'd0);
        check_eq("mid_scnt", obs_scnt(0), 64'd0);
        check_eq("mid_fcnt", obs_fcnt(0), 64'd0);
        model_reset(0);
        model_reset(1);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("post_rst_stall", obs_stall(0), 64'd0);
        step();
        idle(0);

        // config B: LOAD_LAT=2, NSTAGE=4
        do_reset();
        drive(1, 0, 0, 2'b01, 1, 1, 1); step();
        drive(1, 1, 0, 2'b01, 2, 1, 0); #1;
        check_eq("b_stall1", obs_stall(1), 64'd1);
        step(); #1;
        check_eq("b_stall2", obs_stall(1), 64'd1);
        step(); #1;
        check_eq("b_stall_done", obs_stall(1), 64'd0);
        check_eq("b_p0", obs_sel(1, 0), 64'd3);
        step();
        check_eq("b_scnt", obs_scnt(1), 64'd2);

        // config B: 4-bit stall counter saturates after 20 stall cycles
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 2'b01, 1, 1, 1); step();
            drive(1, 1, 0, 2'b01, 2, 1, 0); step(); step(); step();
        end
        check_eq("b_sat", obs_scnt(1), 64'd15);
        idle(1);

        // random traffic on both configurations
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 2; k++) begin
                in_valid[k] = ($urandom_range(0, 3) != 0);
                in_rs[k][0] = 5'($urandom_range(0, 4));
                in_rs[k][1] = 5'($urandom_range(0, 4));
                in_used[k]  = 2'($urandom_range(0, 3));
                in_rd[k]    = 5'($urandom_range(0, 4));
                in_wr[k]    = ($urandom_range(0, 4) != 0);
                in_ld[k]    = ($urandom_range(0, 2) == 0);
                in_flush[k] = ($urandom_range(0, 9) == 0);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
Parametrised hazard-detection and operand-bypass controller for the in-order RISC-V integer pipeline.
- Sits beside the ID stage and tracks destination registers of the last NSTAGE issued instructions in an internal slot shift register.
- Each cycle it generates per-read-port forwarding selects and a load-use stall.
- Generalises the fixed 2-port, 5-stage, 1-cycle-load scheme to configurable read-port count, post-ID depth and load latency.
- Adds flush handling and saturating stall/bypass performance counters.

Parameters:
NRP, 2, number of register read ports in ID (1..4)
NSTAGE, 3, pipeline stages after ID (EX, MEM, WB by default); 2..6
LOAD_LAT, 1, extra cycles after EX before load data is forwardable; 0..NSTAGE-2
CNTW, 32, width of performance counters
SELW, $clog2(NSTAGE), width of one forward select (derived, not overridable)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs  in  NRP*5  source register indices, port p at [5p+4:5p]
id_rs_used  in  NRP  port p actually reads its register
id_rd  in  5  destination register of ID instruction
id_regwrite  in  1  ID instruction writes id_rd
id_is_load  in  1  ID instruction is a load
flush  in  1  squash the ID instruction (taken branch/jump)
stall  out  1  hold PC and IF/ID, inject bubble into EX
fwd_sel  out  NRP*SELW  per-port select; 0 = regfile, j = pipeline register after stage j (1 = EX/MEM, 2 = MEM/WB, ...)
stall_cnt  out  CNTW  cycles with stall=1, saturating
fwd_cnt  out  CNTW  issued instructions with at least one nonzero fwd_sel, saturating

Behaviour:
- Slot j (1..NSTAGE) holds {valid, rd, wr, ld} of the instruction issued j cycles ago. Slot 1 is the instruction now in EX.
- Each rising edge, slots shift: slot j+1 <= slot j, and slot NSTAGE is discarded.
- Slot 1 load value:
  - ID fields when id_valid & !stall & !flush.
  - Otherwise a bubble (valid=0).
- Match(p, j) = id_valid & id_rs_used[p] & slot_j.valid & slot_j.wr & slot_j.rd == id_rs[p] & id_rs[p] != 0. x0 never matches.
- For each port p, the producer is the matching slot with the smallest j (youngest wins).
- Ready(j) = (j >= 1 + (slot_j.ld ? LOAD_LAT : 0)).
- Port forwarding select:
  - fwd_sel[p] = j if the producer exists, j < NSTAGE and Ready(j).
  - fwd_sel[p] = 0 otherwise.
  - Slot NSTAGE is in WB; the regfile is write-through, so slot NSTAGE needs no forwarding.
- stall = !flush & OR over p of (producer exists & !Ready(j)).
  - A load at slot 1 with LOAD_LAT=1 gives exactly one stall cycle.
  - LOAD_LAT=L gives L stall cycles.
- stall and fwd_sel are combinational from the inputs and slot state; zero-latency, same cycle.
- fwd_sel is don't-care while stall=1; the bench checks it only when stall=0.
- flush has priority over stall: stall=0, bubble into slot 1, older slots shift normally.
- Counter updates:
  - stall_cnt increments each cycle with stall=1.
  - fwd_cnt increments when an instruction enters slot 1 with any nonzero fwd_sel.
  - Both hold at 2^CNTW-1.
- Reset, asynchronous, any time including mid-stall:
  - All slots invalid; counters 0.
  - stall=0 and fwd_sel=0 while no input matches.
  - The first edge after deassertion behaves as from an empty pipeline.

Test Plan:
- Reset, then ADDI x1,x0,5 / ADDI x2,x0,10 / ADD x3,x1,x2 issued back-to-back -> at ADD: fwd_sel port0=2, port1=1, stall=0; fwd_cnt=1.
- SUB x4,x3,x1 right after the above -> port0=1 (x3), port1=3→0 (x1 at slot 3 = WB, regfile); AND x5,x4,x2 next -> port0=1, port1=0.
- LW x1,0(x0) then ADDI x2,x1,5, LOAD_LAT=1 -> stall=1 for exactly 1 cycle, then fwd_sel port0=2, stall_cnt=1; SW x2,4(x0) next -> port1=1.
- Same sequence with LOAD_LAT=2, NSTAGE=4 -> 2 stall cycles, then port0=3; stall_cnt=2.
- Writes to x0 followed by a read of x0, and a consumer with id_rs_used=0 -> fwd_sel=0, stall=0 throughout.
- flush asserted during a load-use stall -> stall drops the same cycle, bubble enters slot 1.
- Reset mid-stall -> stall=0 immediately and counters 0.
- CNTW=4 with 20 stall cycles -> stall_cnt=15.
